// File: rtl/truxton2_gfx_pkg.sv
// truxton2_gfx_pkg: shared widths, slot indices and FSM state codes for the graphics-ROM arbiter
package truxton2_gfx_pkg;
   localparam int ADDR_W = 22;
   localparam int DATA_W = 32;
   localparam int BA_DW = 16;
   localparam logic [1:0] SLOT_SPR = 2'd0;
   localparam logic [1:0] SLOT_SCR0 = 2'd1;
   localparam logic [1:0] SLOT_SCR1 = 2'd2;
   localparam logic [1:0] SLOT_SCR2 = 2'd3;
   typedef logic [2:0] state_t;
   localparam state_t IDLE = 3'd0;
   localparam state_t RD_LO = 3'd1;
   localparam state_t WT_LO = 3'd2;
   localparam state_t RD_HI = 3'd3;
   localparam state_t WT_HI = 3'd4;
endpackage

// File: rtl/truxton2_gfx_arbiter_rr_pick.sv
// truxton2_rr_pick: combinational 4-way round-robin selector
//   pending  : per-slot request vector
//   last     : slot granted most recently (searched last)
//   spr_prio : when set, a pending slot 0 wins outright
//   grant    : selected slot index
//   any      : at least one slot is pending
module truxton2_rr_pick
   import truxton2_gfx_pkg::*;
(
   input  logic [3:0] pending,
   input  logic [1:0] last,
   input  logic       spr_prio,
   output logic [1:0] grant,
   output logic       any
);
   logic [1:0] idx;
   // walk from farthest to nearest so the nearest pending slot after last wins
   always_comb begin
      grant = last;
      idx = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (pending[idx]) grant = idx;
      end
      if (spr_prio && pending[SLOT_SPR]) grant = SLOT_SPR;
      any = |pending;
   end
endmodule

// File: rtl/truxton2_gfx_arbiter.sv
// truxton2_gfx_arbiter: shares one SDRAM bank read port among four cached 32-bit graphics-ROM slots
//   CLK, RESET (async, active-high), DOWNLOADING : clock, reset, ROM load in progress
//   SLOT_CS/SLOT_ADDR -> SLOT_OK/SLOT_DOUT      : per-slot request and one-entry cache result
//   BA_ADDR/BA_RD <- BA_ACK/BA_RDY/DATA_READ    : bank port, two 16-bit reads per fetch
//   TRUXTON2_GFXARB_SPRPRIO_EN                  : give slot 0 fixed priority over the round-robin
module truxton2_gfx_arbiter
   import truxton2_gfx_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BANK_OFFSET = 22'h0,
   parameter int NSLOT = 4
)(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    DOWNLOADING,
   input  logic [NSLOT-1:0]        SLOT_CS,
   input  logic [NSLOT*ADDR_W-1:0] SLOT_ADDR,
   output logic [NSLOT-1:0]        SLOT_OK,
   output logic [NSLOT*DATA_W-1:0] SLOT_DOUT,
   output logic [ADDR_W-1:0]       BA_ADDR,
   output logic                    BA_RD,
   input  logic                    BA_ACK,
   input  logic                    BA_RDY,
   input  logic [BA_DW-1:0]        DATA_READ
);
`ifdef TRUXTON2_GFXARB_SPRPRIO_EN
   localparam logic SPR_PRIO = 1'b1;
`else
   localparam logic SPR_PRIO = 1'b0;
`endif
   state_t state;
   logic [1:0] last, gidx, pick;
   logic any, dl_seen;
   logic [ADDR_W-1:0] gaddr;
   logic [BA_DW-1:0] lo;
   logic [NSLOT-1:0] valid, hit, pending;
   logic [ADDR_W-1:0] tag [NSLOT];
   logic [DATA_W-1:0] data [NSLOT];
   logic [ADDR_W-1:0] addr [NSLOT];
   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      assign addr[i] = SLOT_ADDR[i*ADDR_W +: ADDR_W];
      assign hit[i] = valid[i] && tag[i] == addr[i];
      assign SLOT_DOUT[i*DATA_W +: DATA_W] = data[i];
   end
   assign SLOT_OK = SLOT_CS & hit;
   assign pending = SLOT_CS & ~hit;
   truxton2_rr_pick u_pick (
      .pending  (pending),
      .last     (last),
      .spr_prio (SPR_PRIO),
      .grant    (pick),
      .any      (any)
   );
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         last <= 2'd3;
         gidx <= 2'd0;
         gaddr <= '0;
         lo <= '0;
         valid <= '0;
         dl_seen <= 1'b0;
         BA_ADDR <= '0;
         BA_RD <= 1'b0;
         for (int k = 0; k < NSLOT; k++) begin
            tag[k] <= '0;
            data[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (!DOWNLOADING && any) begin
               gidx <= pick;
               gaddr <= addr[pick];
               last <= (SPR_PRIO && pick == SLOT_SPR) ? last : pick;
               // bank words are 16 bits, so each 32-bit slot word spans two; bit 21 falls off
               BA_ADDR <= BANK_OFFSET + {addr[pick][20:0], 1'b0};
               BA_RD <= 1'b1;
               dl_seen <= 1'b0;
               state <= RD_LO;
            end
            RD_LO, RD_HI: if (BA_ACK) begin
               BA_RD <= 1'b0;
               state <= (state == RD_LO) ? WT_LO : WT_HI;
            end
            WT_LO: if (BA_RDY) begin
               lo <= DATA_READ;
               BA_ADDR <= BA_ADDR + 22'd1;
               BA_RD <= 1'b1;
               state <= RD_HI;
            end
            WT_HI: if (BA_RDY) begin
               data[gidx] <= {DATA_READ, lo};
               tag[gidx] <= gaddr;
               valid[gidx] <= ~dl_seen;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // a download seen at any point of a fetch keeps its result from being trusted
         if (DOWNLOADING) begin
            valid <= '0;
            dl_seen <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_truxton2_gfx_arbiter.sv
// tb_truxton2_gfx_arbiter: directed self-checking bench for truxton2_gfx_arbiter
module tb_truxton2_gfx_arbiter;
   logic clk = 1'b0, rst = 1'b1, dl = 1'b0, ba_ack = 1'b0, ba_rdy = 1'b0;
   logic [3:0] cs = '0;
   logic [87:0] slot_addr = '0;
   logic [15:0] data_read = '0;
   logic [3:0] ok, ok2;
   logic [127:0] dout, dout2;
   logic [21:0] ba_addr, ba_addr2;
   logic ba_rd, ba_rd2;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   truxton2_gfx_arbiter dut (
      .CLK(clk), .RESET(rst), .DOWNLOADING(dl), .SLOT_CS(cs), .SLOT_ADDR(slot_addr),
      .SLOT_OK(ok), .SLOT_DOUT(dout), .BA_ADDR(ba_addr), .BA_RD(ba_rd),
      .BA_ACK(ba_ack), .BA_RDY(ba_rdy), .DATA_READ(data_read)
   );
   truxton2_gfx_arbiter #(.BANK_OFFSET(22'h3FFFFE)) dut2 (
      .CLK(clk), .RESET(rst), .DOWNLOADING(dl), .SLOT_CS(cs), .SLOT_ADDR(slot_addr),
      .SLOT_OK(ok2), .SLOT_DOUT(dout2), .BA_ADDR(ba_addr2), .BA_RD(ba_rd2),
      .BA_ACK(ba_ack), .BA_RDY(ba_rdy), .DATA_READ(data_read)
   );
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   function automatic logic [87:0] put(input logic [87:0] v, input int k, input logic [21:0] a);
      logic [87:0] r;
      r = v;
      r[k*22 +: 22] = a;
      return r;
   endfunction
   task automatic wait_rd();
      int n;
      n = 0;
      while (!ba_rd && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rd_wait", ba_rd, 1'b1);
      chk("rd_twin", ba_rd2, ba_rd);
   endtask
   // bank model: ACK arrives together with a junk RDY, then the real RDY a cycle later
   task automatic serve(input logic [15:0] lo, input logic [15:0] hi, input logic [87:0] mid,
                        output logic [21:0] al, output logic [21:0] ah,
                        output logic [21:0] a2l, output logic [21:0] a2h);
      wait_rd();
      al = ba_addr;
      a2l = ba_addr2;
      ba_ack = 1'b1;
      ba_rdy = 1'b1;
      data_read = 16'hDEAD;
      @(negedge clk);
      ba_ack = 1'b0;
      data_read = lo;
      slot_addr = mid;
      @(negedge clk);
      ah = ba_addr;
      a2h = ba_addr2;
      ba_ack = 1'b1;
      data_read = 16'hBEEF;
      @(negedge clk);
      ba_ack = 1'b0;
      data_read = hi;
      @(negedge clk);
      ba_rdy = 1'b0;
   endtask
   initial begin
      logic [21:0] al, ah, a2l, a2h;
      logic [21:0] refetch [4];
      refetch = '{22'h200, 22'h40, 22'h800, 22'h600};
      #2;
      chk("rst_rd", ba_rd, 1'b0);
      chk("rst_addr", ba_addr, 22'h0);
      chk("rst_ok", ok, 4'h0);
      chk("rst_dout", dout, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      cs = 4'b0010;
      slot_addr = put(slot_addr, 1, 22'h100);
      serve(16'h1234, 16'hABCD, slot_addr, al, ah, a2l, a2h);
      chk("miss_lo", al, 22'h200);
      chk("miss_hi", ah, 22'h201);
      chk("miss_dout", dout[63:32], 32'hABCD1234);
      chk("miss_ok", ok, 4'b0010);
      repeat (3) @(negedge clk);
      chk("hit_ok", ok, 4'b0010);
      chk("hit_idle", ba_rd, 1'b0);
      cs = 4'b0110;
      slot_addr = put(slot_addr, 2, 22'h10);
      serve(16'h1111, 16'h2222, put(slot_addr, 2, 22'h20), al, ah, a2l, a2h);
      chk("chg_lo", al, 22'h20);
      chk("chg_ok", ok, 4'b0010);
      slot_addr = put(slot_addr, 2, 22'h10);
      #1;
      chk("chg_tag", ok, 4'b0110);
      slot_addr = put(slot_addr, 2, 22'h20);
      #1;
      serve(16'h3333, 16'h4444, slot_addr, al, ah, a2l, a2h);
      chk("chg_refetch", al, 22'h40);
      chk("chg_dout", dout[95:64], 32'h44443333);
      chk("chg_ok2", ok, 4'b0110);
      cs = 4'hF;
      slot_addr = put(put(slot_addr, 0, 22'h300), 3, 22'h400);
      serve(16'h5555, 16'h6666, slot_addr, al, ah, a2l, a2h);
      chk("fill_s3", al, 22'h800);
      serve(16'h7777, 16'h8888, slot_addr, al, ah, a2l, a2h);
      chk("fill_s0", al, 22'h600);
      chk("fill_ok", ok, 4'hF);
      chk("fill_dout", dout, {32'h66665555, 32'h44443333, 32'hABCD1234, 32'h88887777});
      dl = 1'b1;
      @(negedge clk);
      chk("dl_ok", ok, 4'h0);
      repeat (4) @(negedge clk);
      chk("dl_rd", ba_rd, 1'b0);
      dl = 1'b0;
      for (int k = 0; k < 4; k++) begin
         serve(16'h0A00 + 16'(k), 16'h0B00 + 16'(k), slot_addr, al, ah, a2l, a2h);
         chk("refetch", al, refetch[k]);
      end
      chk("refetch_ok", ok, 4'hF);
      cs = 4'b0001;
      slot_addr = put(slot_addr, 0, 22'h1);
      wait_rd();
      chk("arst_lo", ba_addr, 22'h2);
      chk("wrap_lo1", ba_addr2, 22'h0);
      ba_ack = 1'b1;
      @(negedge clk);
      ba_ack = 1'b0;
      ba_rdy = 1'b1;
      data_read = 16'h9999;
      @(negedge clk);
      ba_rdy = 1'b0;
      chk("arst_hi_rd", ba_rd, 1'b1);
      chk("arst_hi", ba_addr, 22'h3);
      chk("wrap_hi1", ba_addr2, 22'h1);
      rst = 1'b1;
      #1;
      chk("arst_rd", ba_rd, 1'b0);
      chk("arst_ok", ok, 4'h0);
      chk("arst_addr", ba_addr, 22'h0);
      @(negedge clk);
      rst = 1'b0;
      cs = 4'hF;
      slot_addr = {22'h3, 22'h2, 22'h1, 22'h0};
      for (int n = 0; n < 6; n++) begin
         serve(16'hC000 + 16'(n), 16'hD000 + 16'(n),
               put(slot_addr, n % 4, 22'(16 * (n / 4 + 1) + n % 4)), al, ah, a2l, a2h);
         chk("rr_grant", al, 22'(2 * (16 * (n / 4) + n % 4)));
         if (n == 0) begin
            chk("wrap_lo0", a2l, 22'h3FFFFE);
            chk("wrap_hi0", a2h, 22'h3FFFFF);
         end
      end
      chk("rr_dout", dout[63:32], 32'hD005C005);
      chk("twin_ok", ok2, ok);
      chk("twin_dout", dout2, dout);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
